// File: rtl/conv_job_scheduler.sv
// Job FIFO plus one-hot launch FSM driving the XNOR/popcount conv engine's run/busy pair.
// Optional SCHED_PERF_CNT_EN adds done_cycles (cycles from eng_run to busy fall).
module conv_job_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int ADDR_W     = 12,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_base,
  input  logic [ADDR_W-1:0] job_out_base,
  input  logic [ADDR_W-1:0] job_w_addr,
  input  logic [1:0]        job_dim,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              eng_run,
  output logic [ADDR_W-1:0] eng_in_base,
  output logic [ADDR_W-1:0] eng_out_base,
  output logic [ADDR_W-1:0] eng_w_addr,
  output logic [1:0]        eng_dim,
  input  logic              eng_busy,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [TAG_W-1:0]  done_tag,
  output logic              done_err,
  output logic              sched_idle
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]       done_cycles
`endif
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [9:0]      TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [9:0]      WAIT_LAST   = 10'd3;
  localparam logic [1:0]      DIM_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        dim;
    logic [TAG_W-1:0]  tag;
  } job_t;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_WAIT   = 5'b00100,
    S_RUN    = 5'b01000,
    S_REPORT = 5'b10000
  } state_t;

  job_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  job_t             w_job_in;
  job_t             w_head;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_rpt_load;
  logic             w_rpt_err;
  logic             w_cnt_clr;
  logic [9:0]       r_cnt;
  job_t             r_job;
  logic             r_done_err;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = job_valid & ~w_full;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_job_in = '{in_base: job_in_base, out_base: job_out_base, w_addr: job_w_addr,
                      dim: job_dim, tag: job_tag};

  // NOTE: payload storage is not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_job_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rpt_load  = 1'b0;
    w_rpt_err   = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.dim == DIM_ILLEGAL) begin
            w_state_nxt = S_REPORT;
            w_rpt_load  = 1'b1;
            w_rpt_err   = 1'b1;
          end else begin
            w_state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT;
        w_cnt_clr   = 1'b1;
      end
      S_WAIT: begin
        if (eng_busy) begin
          w_state_nxt = S_RUN;
        end else if (r_cnt == WAIT_LAST) begin
          w_state_nxt = S_REPORT;
          w_rpt_load  = 1'b1;
          w_rpt_err   = 1'b1;
        end
      end
      S_RUN: begin
        // Entered only with busy high, so a low sample here is the falling edge.
        if (!eng_busy) begin
          w_state_nxt = S_REPORT;
          w_rpt_load  = 1'b1;
        end else if (r_cnt >= TIMEOUT_CNT) begin
          w_state_nxt = S_REPORT;
          w_rpt_load  = 1'b1;
          w_rpt_err   = 1'b1;
        end
      end
      S_REPORT: begin
        if (done_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_job      <= '0;
      r_done_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_pop)      r_job      <= w_head;
      if (w_rpt_load) r_done_err <= w_rpt_err;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT || r_state == S_RUN) && r_cnt != '1) begin
        r_cnt <= r_cnt + 10'd1;
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] r_perf;
  logic [15:0] r_done_cycles;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_perf        <= '0;
      r_done_cycles <= '0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_perf <= '0;
      end else if ((r_state == S_WAIT || r_state == S_RUN) && r_perf != 16'hFFFF) begin
        r_perf <= r_perf + 16'd1;
      end
      if (w_rpt_load) begin
        if (w_rpt_err)               r_done_cycles <= '0;
        else if (r_perf == 16'hFFFF) r_done_cycles <= r_perf;
        else                         r_done_cycles <= r_perf + 16'd1;
      end
    end
  end

  assign done_cycles = r_done_cycles;
`endif

  assign job_ready    = ~w_full;
  assign eng_run      = (r_state == S_LAUNCH);
  assign eng_in_base  = r_job.in_base;
  assign eng_out_base = r_job.out_base;
  assign eng_w_addr   = r_job.w_addr;
  assign eng_dim      = r_job.dim;
  assign done_valid   = (r_state == S_REPORT);
  assign done_tag     = r_job.tag;
  assign done_err     = r_done_err;
  assign sched_idle   = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Self-checking bench for conv_job_scheduler: behavioural engine, in-order job scoreboard,
// and scenario tasks covering launch, back-pressure, illegal dims, timeouts and reset.
module tb_conv_job_scheduler;

  localparam int TAG_W   = 4;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [ADDR_W-1:0] job_in_base = '0;
  logic [ADDR_W-1:0] job_out_base = '0;
  logic [ADDR_W-1:0] job_w_addr = '0;
  logic [1:0]        job_dim = '0;
  logic [TAG_W-1:0]  job_tag = '0;
  logic              eng_run;
  logic [ADDR_W-1:0] eng_in_base;
  logic [ADDR_W-1:0] eng_out_base;
  logic [ADDR_W-1:0] eng_w_addr;
  logic [1:0]        eng_dim;
  logic              eng_busy = 1'b0;
  logic              done_valid;
  logic              done_ready = 1'b1;
  logic [TAG_W-1:0]  done_tag;
  logic              done_err;
  logic              sched_idle;

  conv_job_scheduler #(
    .FIFO_DEPTH(4), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_b(reset_b),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_in_base(job_in_base), .job_out_base(job_out_base), .job_w_addr(job_w_addr),
    .job_dim(job_dim), .job_tag(job_tag),
    .eng_run(eng_run), .eng_in_base(eng_in_base), .eng_out_base(eng_out_base),
    .eng_w_addr(eng_w_addr), .eng_dim(eng_dim), .eng_busy(eng_busy),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
    .done_err(done_err), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        dim;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } job_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             err;
  } done_t;

  // Reference model: jobs in acceptance order; the ones with a legal dim are launched in that order.
  job_t  exp_q[$];
  job_t  run_exp_q[$];
  done_t obs_done_q[$];
  job_t  obs_run_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int runs = 0;
  int runs_served = 0;
  int run_cyc = 0;
  int done_rise_cyc = 0;
  int busy_fall_cyc = 0;
  int cfg_changes = 0;
  int busy_rem = 0;
  int busy_len = 10;
  bit eng_never = 1'b0;
  bit rand_busy = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;
  logic prev_dv = 1'b0;
  logic [ADDR_W-1:0] snap_in, snap_out, snap_w;
  logic [1:0] snap_dim;
  int ob0, rb0, cc0;

  always @(posedge clk) cyc++;

  // Behavioural engine: busy rises the cycle after eng_run and stays high for the chosen length.
  always @(posedge clk) begin
    #1;
    if (!reset_b) begin
      eng_busy    = 1'b0;
      busy_rem    = 0;
      runs_served = runs;
    end else if (runs != runs_served) begin
      runs_served = runs;
      if (!eng_never) begin
        eng_busy = 1'b1;
        busy_rem = rand_busy ? int'($urandom_range(1, 15)) : busy_len;
      end
    end else if (eng_busy) begin
      busy_rem--;
      if (busy_rem == 0) begin
        eng_busy      = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    done_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  always @(negedge clk) begin
    if (reset_b) begin
      if (eng_run) begin
        runs++;
        run_cyc = cyc;
        obs_run_q.push_back('{eng_in_base, eng_out_base, eng_w_addr, eng_dim, '0, 1'b0});
        snap_in = eng_in_base; snap_out = eng_out_base; snap_w = eng_w_addr; snap_dim = eng_dim;
      end
      if (eng_busy && {eng_in_base, eng_out_base, eng_w_addr, eng_dim} !== {snap_in, snap_out, snap_w, snap_dim})
        cfg_changes++;
      if (done_valid && !prev_dv) done_rise_cyc = cyc;
      if (done_valid && done_ready) obs_done_q.push_back('{done_tag, done_err});
    end
    prev_dv = done_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic start_test();
    exp_q.delete();
    run_exp_q.delete();
    ob0 = obs_done_q.size();
    rb0 = obs_run_q.size();
    cc0 = cfg_changes;
  endtask

  task automatic push_job(input logic [1:0] dim, input logic [TAG_W-1:0] tag, output int drive_cyc);
    job_t j;
    int   waited = 0;
    j.in_base  = ADDR_W'($urandom);
    j.out_base = ADDR_W'($urandom);
    j.w_addr   = ADDR_W'($urandom);
    j.dim      = dim;
    j.tag      = tag;
    j.err      = (dim == 2'b11) || eng_never || (!rand_busy && busy_len > TIMEOUT);
    drive_cyc  = cyc;
    while (!job_ready && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!job_ready) begin
      n_checks++;
      $display("FAIL push_wait tag=%0h: job_ready=%0b after %0d cycles, required 1", tag, job_ready, waited);
    end else begin
      job_valid = 1'b1; job_in_base = j.in_base; job_out_base = j.out_base;
      job_w_addr = j.w_addr; job_dim = dim; job_tag = tag;
      drive_cyc = cyc;
      @(posedge clk); #1;
      job_valid = 1'b0;
      exp_q.push_back(j);
      if (dim != 2'b11) run_exp_q.push_back(j);
    end
  endtask

  task automatic wait_done(input int n, input string ctx);
    int waited = 0;
    while (obs_done_q.size() - ob0 < n && waited < 4000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (obs_done_q.size() - ob0 < n) begin
      n_checks++;
      $display("FAIL %s_wait: %0d done records, required %0d", ctx, obs_done_q.size() - ob0, n);
    end
    @(posedge clk); #1;
  endtask

  // Compares everything observed since start_test against the model queues.
  task automatic score_model(input string ctx);
    int nd = obs_done_q.size() - ob0;
    int nr = obs_run_q.size() - rb0;
    n_checks++;
    if (nd != exp_q.size()) $display("FAIL %s_done_count: got %0d, required %0d", ctx, nd, exp_q.size());
    else n_pass++;
    for (int i = 0; i < nd && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_done_q[ob0+i].tag !== exp_q[i].tag || obs_done_q[ob0+i].err !== exp_q[i].err)
        $display("FAIL %s_done[%0d]: tag=%0h err=%0b, required tag=%0h err=%0b", ctx, i,
                 obs_done_q[ob0+i].tag, obs_done_q[ob0+i].err, exp_q[i].tag, exp_q[i].err);
      else n_pass++;
    end
    n_checks++;
    if (nr != run_exp_q.size()) $display("FAIL %s_run_count: got %0d, required %0d", ctx, nr, run_exp_q.size());
    else n_pass++;
    for (int i = 0; i < nr && i < run_exp_q.size(); i++) begin
      n_checks++;
      if ({obs_run_q[rb0+i].in_base, obs_run_q[rb0+i].out_base, obs_run_q[rb0+i].w_addr, obs_run_q[rb0+i].dim}
          !== {run_exp_q[i].in_base, run_exp_q[i].out_base, run_exp_q[i].w_addr, run_exp_q[i].dim})
        $display("FAIL %s_run_cfg[%0d]: got %h/%h/%h/%0d, required %h/%h/%h/%0d", ctx, i,
                 obs_run_q[rb0+i].in_base, obs_run_q[rb0+i].out_base, obs_run_q[rb0+i].w_addr,
                 obs_run_q[rb0+i].dim, run_exp_q[i].in_base, run_exp_q[i].out_base,
                 run_exp_q[i].w_addr, run_exp_q[i].dim);
      else n_pass++;
    end
    n_checks++;
    if (cfg_changes - cc0 != 0) $display("FAIL %s_cfg_stable: %0d changes while busy, required 0", ctx, cfg_changes - cc0);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string ctx);
    n_checks++;
    if (job_ready !== 1'b1) $display("FAIL %s_job_ready: got %0b, required 1", ctx, job_ready); else n_pass++;
    n_checks++;
    if (eng_run !== 1'b0) $display("FAIL %s_eng_run: got %0b, required 0", ctx, eng_run); else n_pass++;
    n_checks++;
    if ({eng_in_base, eng_out_base, eng_w_addr, eng_dim} !== '0)
      $display("FAIL %s_eng_cfg: got %h/%h/%h/%0d, required all 0", ctx, eng_in_base, eng_out_base, eng_w_addr, eng_dim);
    else n_pass++;
    n_checks++;
    if ({done_valid, done_tag, done_err} !== '0)
      $display("FAIL %s_done: got valid=%0b tag=%0h err=%0b, required all 0", ctx, done_valid, done_tag, done_err);
    else n_pass++;
    n_checks++;
    if (sched_idle !== 1'b1) $display("FAIL %s_sched_idle: got %0b, required 1", ctx, sched_idle); else n_pass++;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_released");
  endtask

  task automatic test_single();
    int dc;
    int r0 = runs;
    start_test();
    busy_len = 40;
    push_job(2'b00, 4'd3, dc);
    wait_done(1, "single");
    n_checks++;
    if (runs - r0 != 1) $display("FAIL single_run_pulses: got %0d, required 1", runs - r0); else n_pass++;
    n_checks++;
    if (run_cyc != dc + 2) $display("FAIL single_launch_latency: run at %0d, required %0d", run_cyc, dc + 2); else n_pass++;
    n_checks++;
    if (done_rise_cyc != busy_fall_cyc + 1)
      $display("FAIL single_done_latency: done at %0d, required %0d", done_rise_cyc, busy_fall_cyc + 1);
    else n_pass++;
    n_checks++;
    if (sched_idle !== 1'b1) $display("FAIL single_idle_after: got %0b, required 1", sched_idle); else n_pass++;
    score_model("single");
  endtask

  task automatic test_back_to_back();
    int dc;
    int held_ready = 0;
    start_test();
    busy_len = 80;
    push_job(2'($urandom_range(0, 2)), 4'd0, dc);
    repeat (3) @(posedge clk);
    #1;
    busy_len = 6;
    for (int t = 1; t <= 4; t++) begin
      n_checks++;
      if (job_ready !== 1'b1) $display("FAIL b2b_ready_before_%0d: got %0b, required 1", t, job_ready); else n_pass++;
      push_job(2'($urandom_range(0, 2)), TAG_W'(t), dc);
    end
    n_checks++;
    if (job_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0b, required 0", job_ready); else n_pass++;
    job_valid = 1'b1; job_tag = 4'd5; job_dim = 2'b01;
    job_in_base = ADDR_W'($urandom); job_out_base = ADDR_W'($urandom); job_w_addr = ADDR_W'($urandom);
    repeat (5) begin
      if (job_ready) held_ready++;
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    n_checks++;
    if (held_ready != 0) $display("FAIL b2b_full_held: ready high %0d cycles while full, required 0", held_ready); else n_pass++;
    push_job(2'($urandom_range(0, 2)), 4'd5, dc);
    wait_done(6, "b2b");
    repeat (20) @(posedge clk);
    #1;
    score_model("b2b");
  endtask

  task automatic test_illegal_dim();
    int dc;
    int r0 = runs;
    start_test();
    push_job(2'b11, 4'd7, dc);
    wait_done(1, "illegal");
    n_checks++;
    if (runs != r0) $display("FAIL illegal_no_launch: got %0d pulses, required 0", runs - r0); else n_pass++;
    n_checks++;
    if (done_rise_cyc - dc < 1 || done_rise_cyc - dc > 3)
      $display("FAIL illegal_latency: done %0d cycles after drive, required 1..3", done_rise_cyc - dc);
    else n_pass++;
    score_model("illegal");
  endtask

  task automatic test_no_busy();
    int dc;
    int r0 = runs;
    int first_run;
    int first_done;
    start_test();
    eng_never = 1'b1;
    push_job(2'($urandom_range(0, 2)), 4'd9, dc);
    wait_done(1, "nobusy");
    first_run = run_cyc;
    first_done = done_rise_cyc;
    eng_never = 1'b0;
    n_checks++;
    if (first_done != first_run + 5)
      $display("FAIL nobusy_timeout_cycle: done at %0d, required %0d", first_done, first_run + 5);
    else n_pass++;
    busy_len = 8;
    push_job(2'($urandom_range(0, 2)), 4'd10, dc);
    wait_done(2, "nobusy_next");
    n_checks++;
    if (runs - r0 != 2) $display("FAIL nobusy_next_launch: got %0d pulses, required 2", runs - r0); else n_pass++;
    score_model("nobusy");
  endtask

  task automatic test_backpressure();
    int dc;
    int r1;
    int unstable = 0;
    int waited = 0;
    start_test();
    ready_fixed = 1'b0;
    busy_len = 5;
    push_job(2'b10, 4'd1, dc);
    push_job(2'b00, 4'd2, dc);
    while (!done_valid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    r1 = runs;
    repeat (10) begin
      if (done_valid !== 1'b1 || done_tag !== exp_q[0].tag || done_err !== exp_q[0].err) unstable++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (unstable != 0) $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable); else n_pass++;
    n_checks++;
    if (runs != r1) $display("FAIL bp_no_launch: got %0d pulses during stall, required 0", runs - r1); else n_pass++;
    ready_fixed = 1'b1;
    wait_done(2, "bp");
    n_checks++;
    if (runs - r1 != 1) $display("FAIL bp_launch_after: got %0d pulses, required 1", runs - r1); else n_pass++;
    score_model("bp");
  endtask

  task automatic test_timeout();
    int dc;
    int r0;
    int waited = 0;
    start_test();
    busy_len = 1100;
    push_job(2'b01, 4'hC, dc);
    wait_done(1, "timeout");
    n_checks++;
    if (done_rise_cyc - run_cyc < 1020 || done_rise_cyc - run_cyc > 1030)
      $display("FAIL timeout_cycle: done %0d cycles after run, required 1020..1030", done_rise_cyc - run_cyc);
    else n_pass++;
    r0 = runs;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (runs != r0 || sched_idle !== 1'b1)
      $display("FAIL timeout_busy_ignored: pulses=%0d idle=%0b, required 0 and 1", runs - r0, sched_idle);
    else n_pass++;
    while (eng_busy && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    busy_len = 10;
    score_model("timeout");
  endtask

  task automatic test_random();
    int dc;
    start_test();
    rand_busy = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      push_job(2'($urandom_range(0, 3)), TAG_W'(i), dc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_done(24, "random");
    rand_ready = 1'b0;
    rand_busy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    score_model("random");
  endtask

  task automatic test_reset_mid();
    int dc;
    int r0;
    int d0;
    start_test();
    busy_len = 200;
    push_job(2'b00, 4'd1, dc);
    repeat (4) @(posedge clk);
    #1;
    push_job(2'b01, 4'd2, dc);
    push_job(2'b10, 4'd3, dc);
    repeat (5) @(posedge clk);
    #2;
    r0 = runs;
    d0 = obs_done_q.size();
    reset_b = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    exp_q.delete();
    run_exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (obs_done_q.size() != d0 || runs != r0 || sched_idle !== 1'b1)
      $display("FAIL reset_mid_dropped: done=%0d runs=%0d idle=%0b, required 0, 0, 1",
               obs_done_q.size() - d0, runs - r0, sched_idle);
    else n_pass++;
    busy_len = 10;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal_dim();
    test_no_busy();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
